shift_seq_ctrl: RTL

- Command sequencer that drives the team's 4-bit universal shift register: mode M, parallel data, serial fill bits lin and rin.
- Accepts one command at a time over a valid/ready handshake: load, shift-left N, shift-right N or rotate-left N.
- Drives the register for exactly the required number of clocks, then returns the resulting word with a one-cycle done pulse.
- Sits between the control/CPU-side logic and the shifter, so no upstream block ever drives M directly.

---
 rtl/shift_seq_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the 4-bit universal shift register: it takes one
// load/shift/rotate command at a time and drives M/parin/rin/lin for exactly
// the required number of clocks.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE. cmd_* are ignored
// at all other times. The result is reported with a one-cycle done pulse, and
// result holds that value until the next done.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic             hold,
  input  logic [WIDTH-1:0] q_in,
  output logic [1:0]       M,
  output logic [WIDTH-1:0] parin,
  output logic             rin,
  output logic             lin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROTL = 2'b11;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_LEFT  = 2'b01;
  localparam logic [1:0] M_RIGHT = 2'b10;
  localparam logic [1:0] M_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic accept;
  logic step;

  assign cmd_ready   = (state_q == ST_IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign step        = (state_q == ST_RUN) && !hold;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    fill_d   = fill_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mode_d = cmd_op;
          data_d = cmd_data;
          fill_d = cmd_fill;
          if (cmd_op == OP_LOAD) begin
            cnt_d   = CNT_ONE;
            state_d = ST_RUN;
          end else if (cmd_cnt == CNT_ZERO) begin
            // Zero-count shift: the shifter is never touched, just report Q.
            cnt_d   = CNT_ZERO;
            state_d = ST_FIN;
          end else begin
            cnt_d   = cmd_cnt;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (step) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        // The last shift has landed in the register, so q_in is final here.
        result_d = q_in;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_IDLE;
      mode_q   <= 2'b00;
      cnt_q    <= '0;
      data_q   <= '0;
      fill_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      fill_q   <= fill_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    M     = M_HOLD;
    parin = '0;
    rin   = 1'b0;
    lin   = 1'b0;
    if (step) begin
      case (mode_q)
        OP_LOAD: begin
          M     = M_LOAD;
          parin = data_q;
        end
        OP_SHL: begin
          M   = M_LEFT;
          rin = fill_q;
        end
        OP_SHR: begin
          M   = M_RIGHT;
          lin = fill_q;
        end
        OP_ROTL: begin
          // Rotation feeds the current MSB straight back into bit 0.
          M   = M_LEFT;
          rin = q_in[WIDTH-1];
        end
        default: M = M_HOLD;
      endcase
    end
  end

endmodule
